// File: rtl/vga_sync_gen_pkg.sv
// Shared 640x480@60 raster defaults and helpers for the VGA timing block
// and for the pixel-painting modules that consume its coordinates.
package vga_sync_gen_pkg;

  localparam int CNT_W = 10;

  localparam int H_DISPLAY_DEF = 640;
  localparam int H_FP_DEF      = 16;
  localparam int H_SYNC_DEF    = 96;
  localparam int H_BP_DEF      = 48;

  localparam int V_DISPLAY_DEF = 480;
  localparam int V_FP_DEF      = 10;
  localparam int V_SYNC_DEF    = 2;
  localparam int V_BP_DEF      = 33;

  localparam int H_TOTAL_DEF =
    H_DISPLAY_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int V_TOTAL_DEF =
    V_DISPLAY_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  localparam bit SYNC_POL_DEF = 1'b0;

  typedef logic [CNT_W-1:0] cnt_t;

  typedef struct packed {
    cnt_t h;
    cnt_t v;
  } raster_t;

  function automatic logic in_span(
    input cnt_t c,
    input int   lo,
    input int   len
  );
    return (int'(c) >= lo) && (int'(c) < lo + len);
  endfunction

  function automatic logic sync_lvl(
    input logic active,
    input logic pol
  );
    return active ? pol : ~pol;
  endfunction

endpackage

// File: rtl/vga_sync_gen_tick.sv
// Mod-PIX_DIV divider producing the one-clk pixel enable.
// With PIX_DIV == 1 the counter never leaves zero, so the tick stays high.
module pix_tick_gen #(
  parameter int PIX_DIV = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic tick_o
);

  localparam int W = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
  localparam logic [W-1:0] LAST = W'(PIX_DIV - 1);

  logic [W-1:0] div_q;
  logic [W-1:0] div_d;

  assign tick_o = (div_q == LAST);

  always_comb begin
    div_d = tick_o ? '0 : div_q + 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      div_q <= '0;
    end else begin
      div_q <= div_d;
    end
  end

endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster generator: pixel tick, H/V counters, registered syncs,
// blanking decode and a frame tick at the start of vertical blanking.
module vga_sync_gen
  import vga_sync_gen_pkg::*;
#(
  parameter int PIX_DIV   = 2,
  parameter int H_DISPLAY = H_DISPLAY_DEF,
  parameter int H_FP      = H_FP_DEF,
  parameter int H_SYNC    = H_SYNC_DEF,
  parameter int H_BP      = H_BP_DEF,
  parameter int V_DISPLAY = V_DISPLAY_DEF,
  parameter int V_FP      = V_FP_DEF,
  parameter int V_SYNC    = V_SYNC_DEF,
  parameter int V_BP      = V_BP_DEF,
  parameter bit SYNC_POL  = SYNC_POL_DEF
) (
  input  logic             clk,
  input  logic             reset,
  output logic             p_tick,
  output logic [CNT_W-1:0] pix_x,
  output logic [CNT_W-1:0] pix_y,
  output logic             video_on,
  output logic             hsync,
  output logic             vsync,
  output logic             frame_tick
);

  localparam int H_TOTAL = H_DISPLAY + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_DISPLAY + V_FP + V_SYNC + V_BP;

  localparam cnt_t H_LAST  = cnt_t'(H_TOTAL - 1);
  localparam cnt_t V_LAST  = cnt_t'(V_TOTAL - 1);
  localparam cnt_t V_VLAST = cnt_t'(V_DISPLAY - 1);

  localparam int HS_START = H_DISPLAY + H_FP;
  localparam int VS_START = V_DISPLAY + V_FP;

  raster_t pos_q;
  raster_t pos_d;
  logic    hs_q;
  logic    hs_d;
  logic    vs_q;
  logic    vs_d;
  logic    h_wrap;

  pix_tick_gen #(
    .PIX_DIV(PIX_DIV)
  ) u_tick (
    .clk_i (clk),
    .rst_i (reset),
    .tick_o(p_tick)
  );

  assign h_wrap = (pos_q.h == H_LAST);

  always_comb begin
    pos_d = pos_q;
    if (p_tick) begin
      if (h_wrap) begin
        pos_d.h = '0;
        pos_d.v = (pos_q.v == V_LAST) ? '0 : pos_q.v + 1'b1;
      end else begin
        pos_d.h = pos_q.h + 1'b1;
      end
    end
  end

  // Syncs decode the next position so they move with pix_x/pix_y.
  always_comb begin
    hs_d = sync_lvl(in_span(pos_d.h, HS_START, H_SYNC), SYNC_POL);
    vs_d = sync_lvl(in_span(pos_d.v, VS_START, V_SYNC), SYNC_POL);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pos_q <= '0;
      hs_q  <= ~SYNC_POL;
      vs_q  <= ~SYNC_POL;
    end else begin
      pos_q <= pos_d;
      hs_q  <= hs_d;
      vs_q  <= vs_d;
    end
  end

  assign pix_x = pos_q.h;
  assign pix_y = pos_q.v;
  assign hsync = hs_q;
  assign vsync = vs_q;

  assign video_on = (int'(pos_q.h) < H_DISPLAY) &&
                    (int'(pos_q.v) < V_DISPLAY);

  assign frame_tick = p_tick & h_wrap & (pos_q.v == V_VLAST);

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: three instances (default timing, a shrunken
// raster for whole-frame checks, and PIX_DIV=1 with active-high syncs).
module tb_vga_sync_gen;

  typedef struct packed {
    logic       pt;
    logic [9:0] x;
    logic [9:0] y;
    logic       von;
    logic       hs;
    logic       vs;
    logic       ft;
  } obs_t;

  logic clk = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  logic rst_c = 1'b1;

  always #5 clk = ~clk;

  logic       a_pt, a_von, a_hs, a_vs, a_ft;
  logic [9:0] a_x, a_y;
  logic       b_pt, b_von, b_hs, b_vs, b_ft;
  logic [9:0] b_x, b_y;
  logic       c_pt, c_von, c_hs, c_vs, c_ft;
  logic [9:0] c_x, c_y;

  vga_sync_gen u_a (
    .clk(clk), .reset(rst_a), .p_tick(a_pt),
    .pix_x(a_x), .pix_y(a_y), .video_on(a_von),
    .hsync(a_hs), .vsync(a_vs), .frame_tick(a_ft)
  );

  vga_sync_gen #(
    .PIX_DIV(3),
    .H_DISPLAY(20), .H_FP(3), .H_SYNC(4), .H_BP(5),
    .V_DISPLAY(10), .V_FP(2), .V_SYNC(2), .V_BP(3),
    .SYNC_POL(1'b0)
  ) u_b (
    .clk(clk), .reset(rst_b), .p_tick(b_pt),
    .pix_x(b_x), .pix_y(b_y), .video_on(b_von),
    .hsync(b_hs), .vsync(b_vs), .frame_tick(b_ft)
  );

  vga_sync_gen #(
    .PIX_DIV(1), .SYNC_POL(1'b1)
  ) u_c (
    .clk(clk), .reset(rst_c), .p_tick(c_pt),
    .pix_x(c_x), .pix_y(c_y), .video_on(c_von),
    .hsync(c_hs), .vsync(c_vs), .frame_tick(c_ft)
  );

  obs_t oa, ob, oc;
  assign oa = {a_pt, a_x, a_y, a_von, a_hs, a_vs, a_ft};
  assign ob = {b_pt, b_x, b_y, b_von, b_hs, b_vs, b_ft};
  assign oc = {c_pt, c_x, c_y, c_von, c_hs, c_vs, c_ft};

  // clk edges seen since each instance left reset
  int ka, kb, kc;
  always @(posedge clk or posedge rst_a)
    if (rst_a) ka <= 0; else ka <= ka + 1;
  always @(posedge clk or posedge rst_b)
    if (rst_b) kb <= 0; else kb <= kb + 1;
  always @(posedge clk or posedge rst_c)
    if (rst_c) kc <= 0; else kc <= kc + 1;

  int checks = 0;
  int passed = 0;

  // Raster position is just (elapsed pixel ticks) mod frame size.
  function automatic obs_t model(
    input int k, input int pd,
    input int hd, input int hf, input int hsw, input int hb,
    input int vd, input int vf, input int vsw, input int vb,
    input bit pol, input bit rst
  );
    obs_t o;
    int ht, vt, ticks, pos, x, y;
    ht = hd + hf + hsw + hb;
    vt = vd + vf + vsw + vb;
    ticks = rst ? 0 : k / pd;
    o.pt = rst ? (pd == 1) : ((k % pd) == pd - 1);
    pos = ticks % (ht * vt);
    x = pos % ht;
    y = pos / ht;
    o.x = 10'(x);
    o.y = 10'(y);
    o.von = (x < hd) && (y < vd);
    o.hs = (x >= hd + hf && x < hd + hf + hsw) ? pol : !pol;
    o.vs = (y >= vd + vf && y < vd + vf + vsw) ? pol : !pol;
    o.ft = o.pt && (x == ht - 1) && (y == vd - 1);
    return o;
  endfunction

  function automatic obs_t exp_a();
    return model(ka, 2, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, rst_a);
  endfunction
  function automatic obs_t exp_b();
    return model(kb, 3, 20, 3, 4, 5, 10, 2, 2, 3, 1'b0, rst_b);
  endfunction
  function automatic obs_t exp_c();
    return model(kc, 1, 640, 16, 96, 48, 480, 10, 2, 33, 1'b1, rst_c);
  endfunction

  function automatic string fmt(input obs_t o);
    return $sformatf("pt=%b x=%0d y=%0d von=%b hs=%b vs=%b ft=%b",
                     o.pt, o.x, o.y, o.von, o.hs, o.vs, o.ft);
  endfunction

  task automatic test_reset();
    obs_t e;
    rst_a = 1'b1;
    repeat (3) @(negedge clk);
    e = exp_a();
    checks++;
    if (oa !== e) $display("FAIL reset_state got %s exp %s", fmt(oa), fmt(e));
    else passed++;
    checks++;
    if (a_hs !== 1'b1 || a_vs !== 1'b1)
      $display("FAIL reset_sync got hs=%b vs=%b exp 1 1", a_hs, a_vs);
    else passed++;
    checks++;
    if (a_pt !== 1'b0 || a_von !== 1'b1)
      $display("FAIL reset_pt_von got pt=%b von=%b exp 0 1", a_pt, a_von);
    else passed++;
    rst_a = 1'b0;
    @(negedge clk);
    checks++;
    if (a_pt !== 1'b1 || a_x !== 10'd0)
      $display("FAIL first_tick got pt=%b x=%0d exp pt=1 x=0", a_pt, a_x);
    else passed++;
    @(negedge clk);
    checks++;
    if (a_pt !== 1'b0 || a_x !== 10'd1)
      $display("FAIL first_step got pt=%b x=%0d exp pt=0 x=1", a_pt, a_x);
    else passed++;
  endtask

  task automatic test_line_timing();
    obs_t e;
    bit hs_l[800];
    bit von_l[800];
    int nt, lowc, first_low, first_high, von_fall;
    nt = 0; lowc = 0; first_low = -1; first_high = -1; von_fall = -1;
    for (int i = 0; i < 3300; i++) begin
      @(negedge clk);
      e = exp_a();
      checks++;
      if (oa !== e)
        $display("FAIL line_raster k=%0d got %s exp %s", ka, fmt(oa), fmt(e));
      else passed++;
      if (a_pt && a_y == 10'd1 && a_x < 10'd800) begin
        nt++;
        hs_l[a_x] = a_hs;
        von_l[a_x] = a_von;
      end
    end
    for (int x = 0; x < 800; x++) begin
      if (!hs_l[x]) begin
        lowc++;
        if (first_low < 0) first_low = x;
      end else if (first_low >= 0 && first_high < 0) begin
        first_high = x;
      end
      if (!von_l[x] && von_fall < 0) von_fall = x;
    end
    checks++;
    if (nt != 800) $display("FAIL line_ticks got %0d exp 800", nt);
    else passed++;
    checks++;
    if (lowc != 96) $display("FAIL hsync_width got %0d exp 96", lowc);
    else passed++;
    checks++;
    if (first_low != 656 || first_high != 752)
      $display("FAIL hsync_edges got %0d..%0d exp 656..752",
               first_low, first_high);
    else passed++;
    checks++;
    if (von_fall != 640) $display("FAIL von_fall got %0d exp 640", von_fall);
    else passed++;
  endtask

  task automatic test_frame_timing();
    obs_t e;
    int last_ft, ft_cnt, vs_low, vs_bad, von_bad;
    bit want_start;
    last_ft = -1; ft_cnt = 0; vs_low = 0; vs_bad = 0; von_bad = 0;
    want_start = 1'b0;
    rst_b = 1'b1;
    @(negedge clk);
    e = exp_b();
    checks++;
    if (ob !== e) $display("FAIL b_reset got %s exp %s", fmt(ob), fmt(e));
    else passed++;
    rst_b = 1'b0;
    for (int i = 0; i < 3 * 1632 + 50; i++) begin
      @(negedge clk);
      e = exp_b();
      checks++;
      if (ob !== e)
        $display("FAIL frame_raster k=%0d got %s exp %s", kb, fmt(ob), fmt(e));
      else passed++;
      if (want_start) begin
        checks++;
        if (b_x !== 10'd0 || b_y !== 10'd10)
          $display("FAIL ft_next got x=%0d y=%0d exp 0 10", b_x, b_y);
        else passed++;
        want_start = 1'b0;
      end
      if (b_ft) begin
        ft_cnt++;
        checks++;
        if (b_x !== 10'd31 || b_y !== 10'd9)
          $display("FAIL ft_pos got x=%0d y=%0d exp 31 9", b_x, b_y);
        else passed++;
        if (last_ft >= 0) begin
          checks++;
          if (kb - last_ft != 1632)
            $display("FAIL frame_period got %0d exp 1632", kb - last_ft);
          else passed++;
        end
        last_ft = kb;
        want_start = 1'b1;
      end
      if (b_pt && !b_vs) begin
        if (b_y != 10'd12 && b_y != 10'd13) vs_bad++;
        if (kb <= 1632) vs_low++;
      end
      if (b_von && b_y >= 10'd10) von_bad++;
    end
    checks++;
    if (ft_cnt != 3) $display("FAIL ft_count got %0d exp 3", ft_cnt);
    else passed++;
    checks++;
    if (vs_low != 64) $display("FAIL vsync_width got %0d exp 64", vs_low);
    else passed++;
    checks++;
    if (vs_bad != 0) $display("FAIL vsync_rows got %0d stray exp 0", vs_bad);
    else passed++;
    checks++;
    if (von_bad != 0) $display("FAIL vblank_von got %0d exp 0", von_bad);
    else passed++;
  endtask

  task automatic test_mid_reset();
    obs_t e, rv;
    int n;
    rv = {1'b0, 10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0};
    n = 0;
    e = exp_b();
    while (!(e.x == 10'd24 && e.y == 10'd5) && n < 2000) begin
      @(negedge clk);
      e = exp_b();
      n++;
    end
    checks++;
    if (n >= 2000) $display("FAIL mid_wait got timeout exp x=24 y=5");
    else passed++;
    checks++;
    if (b_hs !== 1'b0 || b_x !== 10'd24)
      $display("FAIL pre_reset got hs=%b x=%0d exp 0 24", b_hs, b_x);
    else passed++;
    @(posedge clk);
    #1 rst_b = 1'b1;
    #1;
    checks++;
    if (ob !== rv) $display("FAIL async_reset got %s exp %s", fmt(ob), fmt(rv));
    else passed++;
    repeat (2) @(negedge clk);
    checks++;
    if (ob !== rv) $display("FAIL reset_hold got %s exp %s", fmt(ob), fmt(rv));
    else passed++;
    rst_b = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      e = exp_b();
      checks++;
      if (ob !== e)
        $display("FAIL restart k=%0d got %s exp %s", kb, fmt(ob), fmt(e));
      else passed++;
      if (i == 2) begin
        checks++;
        if (b_x !== 10'd1 || b_y !== 10'd0)
          $display("FAIL restart_step got x=%0d y=%0d exp 1 0", b_x, b_y);
        else passed++;
      end
    end
  endtask

  task automatic test_pixdiv1();
    obs_t e;
    int pt_low, adv_bad, hic, first_hi, last_hi, px;
    pt_low = 0; adv_bad = 0; hic = 0; first_hi = -1; last_hi = -1;
    rst_c = 1'b1;
    @(negedge clk);
    checks++;
    if (c_pt !== 1'b1 || c_hs !== 1'b0)
      $display("FAIL c_reset got pt=%b hs=%b exp 1 0", c_pt, c_hs);
    else passed++;
    rst_c = 1'b0;
    px = 0;
    for (int i = 0; i < 1700; i++) begin
      @(negedge clk);
      e = exp_c();
      checks++;
      if (oc !== e)
        $display("FAIL div1_raster k=%0d got %s exp %s", kc, fmt(oc), fmt(e));
      else passed++;
      if (c_pt !== 1'b1) pt_low++;
      if (int'(c_x) != (px + 1) % 800) adv_bad++;
      px = int'(c_x);
      if (c_y == 10'd1 && c_hs === 1'b1) begin
        hic++;
        if (first_hi < 0) first_hi = int'(c_x);
        last_hi = int'(c_x);
      end
    end
    checks++;
    if (pt_low != 0) $display("FAIL div1_tick got %0d low exp 0", pt_low);
    else passed++;
    checks++;
    if (adv_bad != 0) $display("FAIL div1_advance got %0d bad exp 0", adv_bad);
    else passed++;
    checks++;
    if (hic != 96 || first_hi != 656 || last_hi != 751)
      $display("FAIL div1_hsync got n=%0d %0d..%0d exp 96 656..751",
               hic, first_hi, last_hi);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_line_timing();
    test_frame_timing();
    test_mid_reset();
    test_pixdiv1();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
